// File: rtl/cim_ark_sbox_responder_if.sv
// Core-to-responder bus for the CIM AddRoundKey / S-box stage.
// The core owns the beat stream and the key writes; the responder drives back state bytes and status.
interface cim_ark_sbox_responder_if;
  logic [15:0]  IN;
  logic         IN_VLD;
  logic         RND_CLR;
  logic         KWE;
  logic [3:0]   KADDR;
  logic [127:0] KDATA;

  logic [7:0]   RIO_00, RIO_01, RIO_02, RIO_03, RIO_04, RIO_05, RIO_06, RIO_07;
  logic [7:0]   RIO_08, RIO_09, RIO_10, RIO_11, RIO_12, RIO_13, RIO_14, RIO_15;

  logic         ARK_DONE;
  logic         SB_DONE;
  logic [3:0]   ROUND;
  logic         OVR;

  modport master (
    output IN, IN_VLD, RND_CLR, KWE, KADDR, KDATA,
    input  RIO_00, RIO_01, RIO_02, RIO_03, RIO_04, RIO_05, RIO_06, RIO_07,
    input  RIO_08, RIO_09, RIO_10, RIO_11, RIO_12, RIO_13, RIO_14, RIO_15,
    input  ARK_DONE, SB_DONE, ROUND, OVR
  );

  modport slave (
    input  IN, IN_VLD, RND_CLR, KWE, KADDR, KDATA,
    output RIO_00, RIO_01, RIO_02, RIO_03, RIO_04, RIO_05, RIO_06, RIO_07,
    output RIO_08, RIO_09, RIO_10, RIO_11, RIO_12, RIO_13, RIO_14, RIO_15,
    output ARK_DONE, SB_DONE, ROUND, OVR
  );
endinterface

// File: rtl/cim_ark_sbox_responder.sv
// Synthesizable stand-in for the analog CIM array: AddRoundKey on an 8-beat byte-pair stream,
// then a single-cycle forward S-box substitution of all 16 state bytes.
module cim_ark_sbox_responder #(
  parameter int unsigned NROUNDS = 10
) (
  input logic CLK,
  input logic RST,
  cim_ark_sbox_responder_if.slave bus
);

  localparam int unsigned NKEYS = NROUNDS + 1;
  localparam int unsigned KW    = 128;
  localparam int unsigned BW    = 8;
  localparam int unsigned RW    = 4;

  localparam logic [0:0] ST_ARK    = 1'b0;
  localparam logic [0:0] ST_LOOKUP = 1'b1;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [0:0]    state, state_nxt;
  logic [2:0]    bc, bc_nxt;
  logic          beat_ok;
  logic          do_lookup;
  logic          ovr_set;

  logic [KW-1:0] key_tab [NKEYS];
  logic [KW-1:0] key_cur;
  logic [15:0]   ark_pair;

  logic [BW-1:0] rio      [16];
  logic [BW-1:0] addr_reg [16];
  logic [RW-1:0] round;
  logic          ark_done;
  logic          sb_done;
  logic          ovr;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_ARK;
      bc    <= '0;
    end else begin
      state <= state_nxt;
      bc    <= bc_nxt;
    end
  end

  // Next state; RND_CLR overrides everything, including a pending lookup
  always_comb begin
    state_nxt = state;
    bc_nxt    = bc;
    beat_ok   = 1'b0;
    do_lookup = 1'b0;
    ovr_set   = 1'b0;
    if (bus.RND_CLR) begin
      state_nxt = ST_ARK;
      bc_nxt    = '0;
    end else begin
      case (state)
        ST_ARK: begin
          if (bus.IN_VLD) begin
            beat_ok = 1'b1;
            if (bc == 3'd7) begin
              bc_nxt    = '0;
              state_nxt = ST_LOOKUP;
            end else begin
              bc_nxt = bc + 3'd1;
            end
          end
        end
        ST_LOOKUP: begin
          do_lookup = 1'b1;
          ovr_set   = bus.IN_VLD;
          state_nxt = ST_ARK;
        end
        default: state_nxt = ST_ARK;
      endcase
    end
  end

  // Key pair for beat bc: bytes 2*bc and 2*bc+1 of the current round key
  assign key_cur  = key_tab[round];
  assign ark_pair = bus.IN ^ key_cur[{3'd7 - bc, 4'b0000} +: 16];

  // Round-key table survives reset; out-of-range indices are dropped
  always_ff @(posedge CLK) begin
    if (bus.KWE && (bus.KADDR <= RW'(NROUNDS))) begin
      key_tab[bus.KADDR] <= bus.KDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int j = 0; j < 16; j++) begin
        rio[j]      <= '0;
        addr_reg[j] <= '0;
      end
      round    <= '0;
      ark_done <= 1'b0;
      sb_done  <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      ark_done <= beat_ok && (bc == 3'd7);
      sb_done  <= do_lookup;
      if (ovr_set) begin
        ovr <= 1'b1;
      end
      if (beat_ok) begin
        rio[{bc, 1'b0}]      <= ark_pair[15:8];
        rio[{bc, 1'b1}]      <= ark_pair[7:0];
        addr_reg[{bc, 1'b0}] <= ark_pair[15:8];
        addr_reg[{bc, 1'b1}] <= ark_pair[7:0];
      end else if (do_lookup) begin
        for (int j = 0; j < 16; j++) begin
          rio[j] <= SBOX[addr_reg[j]];
        end
      end
      if (bus.RND_CLR) begin
        round <= '0;
      end else if (do_lookup && (round != RW'(NROUNDS))) begin
        round <= round + RW'(1);
      end
    end
  end

  assign bus.RIO_00   = rio[0];
  assign bus.RIO_01   = rio[1];
  assign bus.RIO_02   = rio[2];
  assign bus.RIO_03   = rio[3];
  assign bus.RIO_04   = rio[4];
  assign bus.RIO_05   = rio[5];
  assign bus.RIO_06   = rio[6];
  assign bus.RIO_07   = rio[7];
  assign bus.RIO_08   = rio[8];
  assign bus.RIO_09   = rio[9];
  assign bus.RIO_10   = rio[10];
  assign bus.RIO_11   = rio[11];
  assign bus.RIO_12   = rio[12];
  assign bus.RIO_13   = rio[13];
  assign bus.RIO_14   = rio[14];
  assign bus.RIO_15   = rio[15];
  assign bus.ARK_DONE = ark_done;
  assign bus.SB_DONE  = sb_done;
  assign bus.ROUND    = round;
  assign bus.OVR      = ovr;

endmodule

// File: tb/tb_cim_ark_sbox_responder.sv
// Directed-sequence bench with random data blocks; expectations come from a GF(2^8)-derived
// S-box, a software AES-128 key expansion and a byte-level model of the frame protocol.
module tb_cim_ark_sbox_responder;
  localparam int unsigned NROUNDS = 10;

  logic CLK = 1'b0;
  logic RST;

  cim_ark_sbox_responder_if bus();

  cim_ark_sbox_responder #(.NROUNDS(NROUNDS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int           total  = 0;
  int           passed = 0;
  logic [7:0]   sbox_m    [256];
  logic [127:0] keys_m    [NROUNDS+1];
  logic [127:0] fips_keys [NROUNDS+1];
  logic [31:0]  w         [44];
  logic [127:0] rio_m, cap_ark, blk;
  int           round_m;
  bit           ovr_m;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Multiplicative inverse in GF(2^8) followed by the FIPS-197 affine transform
  function automatic logic [7:0] sbox_entry(input int x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] rio_all();
    return {bus.RIO_00, bus.RIO_01, bus.RIO_02, bus.RIO_03, bus.RIO_04, bus.RIO_05, bus.RIO_06, bus.RIO_07,
            bus.RIO_08, bus.RIO_09, bus.RIO_10, bus.RIO_11, bus.RIO_12, bus.RIO_13, bus.RIO_14, bus.RIO_15};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    rio_m   = '0;
    round_m = 0;
    ovr_m   = 1'b0;
  endtask

  // One accepted beat k; optional key0 write in the same cycle
  task automatic beat(input int k, input logic [15:0] d, input bit kw, input logic [127:0] kd);
    logic [127:0] key, r;
    key = keys_m[round_m];
    bus.IN = d; bus.IN_VLD = 1'b1;
    bus.KWE = kw; bus.KADDR = 4'd0; bus.KDATA = kd;
    tick();
    bus.IN_VLD = 1'b0; bus.KWE = 1'b0;
    rio_m[127-16*k -: 16] = d ^ key[127-16*k -: 16];
    if (kw) keys_m[0] = kd;
    r = rio_all();
    chk($sformatf("beat%0d_pair", k), 128'(r[127-16*k -: 16]), 128'(rio_m[127-16*k -: 16]));
    chk($sformatf("beat%0d_ark_done", k), 128'(bus.ARK_DONE), 128'(k == 7));
  endtask

  task automatic run_frame(input logic [127:0] b, input int gap, input bit junk, input bit clr,
                           input bit kw0, input logic [127:0] kd);
    for (int k = 0; k < 8; k++) begin
      beat(k, b[127-16*k -: 16], kw0 && (k == 0), kd);
      if (k < 7) repeat (gap) tick();
    end
    cap_ark = rio_all();
    chk("ark_state", cap_ark, rio_m);
    if (junk) begin
      bus.IN = 16'($urandom);
      bus.IN_VLD = 1'b1;
      ovr_m = 1'b1;
    end
    bus.RND_CLR = clr;
    tick();
    bus.IN_VLD = 1'b0; bus.RND_CLR = 1'b0;
    if (clr) begin
      round_m = 0;
    end else begin
      for (int j = 0; j < 16; j++) rio_m[127-8*j -: 8] = sbox_m[rio_m[127-8*j -: 8]];
      round_m = (round_m + 1 > int'(NROUNDS)) ? int'(NROUNDS) : round_m + 1;
    end
    chk("sb_done", 128'(bus.SB_DONE), 128'(!clr));
    chk("sb_state", rio_all(), rio_m);
    chk("round", 128'(bus.ROUND), 128'(round_m));
    chk("ovr", 128'(bus.OVR), 128'(ovr_m));
  endtask

  initial begin
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [127:0] c1_blk;

    for (int x = 0; x < 256; x++) sbox_m[x] = sbox_entry(x);

    // AES-128 key expansion of the FIPS-197 C.1 key
    fips_keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 4; i++) w[i] = fips_keys[0][127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= int'(NROUNDS); r++) fips_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    bus.IN = '0; bus.IN_VLD = 1'b0; bus.RND_CLR = 1'b0;
    bus.KWE = 1'b0; bus.KADDR = '0; bus.KDATA = '0;
    RST = 1'b1;
    tick();
    do_reset();
    chk("rst_rio", rio_all(), 128'h0);
    chk("rst_round", 128'(bus.ROUND), 128'h0);
    chk("rst_flags", 128'({bus.ARK_DONE, bus.SB_DONE, bus.OVR}), 128'h0);

    for (int r = 0; r <= int'(NROUNDS); r++) begin
      bus.KWE = 1'b1; bus.KADDR = 4'(r); bus.KDATA = fips_keys[r];
      tick();
      keys_m[r] = fips_keys[r];
    end
    bus.KWE = 1'b0;

    // FIPS-197 C.1 round 1, contiguous beats
    c1_blk = 128'h00112233445566778899aabbccddeeff;
    run_frame(c1_blk, 0, 1'b0, 1'b0, 1'b0, '0);
    chk("c1_ark", cap_ark, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("c1_sbox", rio_all(), 128'h63cab7040953d051cd60e0e7ba70e18c);
    chk("c1_round", 128'(bus.ROUND), 128'd1);

    // Same block with 3 idle cycles between beats
    do_reset();
    run_frame(c1_blk, 3, 1'b0, 1'b0, 1'b0, '0);
    chk("gap_ark", cap_ark, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("gap_sbox", rio_all(), 128'h63cab7040953d051cd60e0e7ba70e18c);

    // Ninth beat lands in the lookup cycle; tenth starts the next frame
    do_reset();
    run_frame(c1_blk, 0, 1'b1, 1'b0, 1'b0, '0);
    chk("ovr_sbox", rio_all(), 128'h63cab7040953d051cd60e0e7ba70e18c);
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_frame(blk, 0, 1'b0, 1'b0, 1'b0, '0);

    // Twelve frames across the full schedule; round saturates at NROUNDS
    do_reset();
    for (int f = 0; f < 12; f++) begin
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_frame(blk, f % 2, 1'b0, 1'b0, 1'b0, '0);
    end
    chk("sat_key10", cap_ark ^ blk, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset after beat 4 abandons the frame
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = 0; k < 5; k++) beat(k, blk[127-16*k -: 16], 1'b0, '0);
    do_reset();
    chk("midrst_rio", rio_all(), 128'h0);
    chk("midrst_round", 128'(bus.ROUND), 128'h0);
    for (int f = 0; f < 3; f++) begin
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_frame(blk, 0, 1'b0, 1'b0, 1'b0, '0);
    end
    chk("pre_clr_round", 128'(bus.ROUND), 128'd3);

    // RND_CLR during lookup at round 3: no substitution, no SB_DONE
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_frame(blk, 0, 1'b0, 1'b1, 1'b0, '0);
    tick();
    chk("clr_no_sb_done_late", 128'(bus.SB_DONE), 128'h0);

    // RND_CLR with a beat in the same cycle mid-frame: beat dropped, no overrun
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = 0; k < 3; k++) beat(k, blk[127-16*k -: 16], 1'b0, '0);
    bus.RND_CLR = 1'b1; bus.IN_VLD = 1'b1; bus.IN = 16'($urandom);
    tick();
    bus.RND_CLR = 1'b0; bus.IN_VLD = 1'b0;
    chk("clrbeat_rio", rio_all(), rio_m);
    chk("clrbeat_ovr", 128'(bus.OVR), 128'h0);

    // Key0 rewritten in the cycle of beat 0: beat 0 sees the old key
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_frame(blk, 0, 1'b0, 1'b0, 1'b1, {128{1'b1}});
    chk("race_beat0", 128'(cap_ark[127:112] ^ blk[127:112]), 128'(fips_keys[0][127:112]));
    chk("race_rest", 128'(cap_ark[111:0] ^ blk[111:0]), 128'({112{1'b1}}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cim_ark_sbox_responder.md
# cim_ark_sbox_responder

Synthesizable responder for the CIM-side interface of the AES core. It receives the 16-bit `IN` byte-pair stream from the core and performs AddRoundKey against an internal round-key table. It then replaces all 16 state bytes with their S-box values and returns them on the sixteen `RIO_xx` buses. It replaces the behavioural macro model, so the AES core can run in synthesis and FPGA bring-up without the analog CIM array.

## Interface
Parameters:
- `NROUNDS`, 10: last round-key index; the round counter saturates here.

Ports:
- `CLK`  in  1  single clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `IN`  in  16  byte pair from core; [15:8] is the even byte, [7:0] the odd byte.
- `IN_VLD`  in  1  qualifies `IN` as one beat.
- `RND_CLR`  in  1  one-cycle pulse; round counter to 0 and frame restarted (new block).
- `KWE`  in  1  round-key table write enable.
- `KADDR`  in  4  round-key index 0..NROUNDS; writes above NROUNDS are ignored.
- `KDATA`  in  128  round key; byte 0 = [127:120].
- `RIO_00`..`RIO_15`  out  8 each  state bytes returned to core.
- `ARK_DONE`  out  1  one-cycle pulse; all 16 AddRoundKey bytes written.
- `SB_DONE`  out  1  one-cycle pulse; all 16 S-box bytes written.
- `ROUND`  out  4  current round-key index.
- `OVR`  out  1  sticky error: beat presented while not accepting.

## Operation
- States:
  - `ARK`, with beat counter `bc` 0..7.
  - `LOOKUP`, exactly one cycle.
- `ARK`, `IN_VLD`=1, beat `bc`=k, key K=table[`ROUND`]:
  - RIO[2k] <= IN[15:8] ^ K[127-16k -: 8] and RIO[2k+1] <= IN[7:0] ^ K[119-16k -: 8].
  - The same two values are copied into internal addr_reg[2k], addr_reg[2k+1].
  - bc <= bc+1. At k=7, next state is `LOOKUP` and bc <= 0.
- `ARK`, `IN_VLD`=0: hold; no beat consumed. Gaps between beats are allowed.
- `LOOKUP`: needs no input.
  - All 16 RIO[j] <= SBOX[addr_reg[j]].
  - `ROUND` <= min(`ROUND`+1, NROUNDS).
  - Next state is `ARK`.
- `IN_VLD`=1 in `LOOKUP`: beat discarded, `OVR` <= 1 (sticky until `RST`). RIO and addr_reg are unaffected.
- SBOX: internal combinational 256-entry FIPS-197 forward S-box. No external memory file.
- Key table: 11×128 registers, not cleared by `RST`.
  - A write takes effect at the clock edge.
  - A beat in the same cycle as a write to the current index uses the old value.
- `RND_CLR`:
  - `ROUND` <= 0, state <= `ARK`, bc <= 0.
  - RIO, addr_reg and `OVR` unchanged.
  - A beat presented in the same cycle is discarded. `OVR` is not set.
  - Takes priority over `LOOKUP`: no S-box update and no increment.
- Round saturation: after the lookup at `ROUND`=NROUNDS, `ROUND` stays NROUNDS. Further frames use key NROUNDS.

## Timing
- Reset values:
  - All RIO_xx = 0, addr_reg = 0.
  - `ARK_DONE` = `SB_DONE` = `OVR` = 0, `ROUND` = 0.
  - State `ARK`, bc = 0.
- A beat accepted at edge t is visible on the RIO pair after t, i.e. 1-cycle latency.
- `ARK_DONE` is high for exactly the `LOOKUP` cycle, i.e. the cycle after beat 7 is accepted.
- S-box results are visible after the `LOOKUP` edge. `SB_DONE` is high the following cycle, and `ROUND` shows the incremented value in that same cycle.
- Minimum frame is 9 cycles (8 beats + 1 lookup). Back-to-back frames: beat 0 of the next frame is accepted in the cycle `SB_DONE` is high.
- `RST` mid-frame returns all state and outputs to reset values at the next edge. Partial frames are lost.
- The RIO bytes not yet written in a frame keep their previous values.

## Test plan
- FIPS-197 C.1, round 1:
  - Stimulus: key0 = 000102030405060708090a0b0c0d0e0f. Stream 00112233445566778899aabbccddeeff as 8 contiguous beats.
  - During `ARK_DONE`, RIO_00..15 = 00102030405060708090a0b0c0d0e0f0.
  - With `SB_DONE`, RIO = 63cab7040953d051cd60e0e7ba70e18c and `ROUND`=1.
- Gapped beats:
  - Stimulus: same data with `IN_VLD` low for 3 cycles between each beat.
  - Identical RIO results. `ARK_DONE` occurs 1 cycle after the 8th accepted beat.
- Overrun:
  - Stimulus: `IN_VLD` held high for 9 consecutive cycles.
  - The 9th beat (in `LOOKUP`) is dropped and `OVR`=1.
  - S-box result is unchanged from the first scenario.
  - The 10th beat is accepted as beat 0 of the next frame.
- Saturation:
  - Stimulus: load the FIPS key schedule and run 12 frames.
  - `ROUND` goes 1..10 and then stays 10. Frames 11–12 use key10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Reset and clear:
  - Assert `RST` after beat 4: all RIO=0, `ROUND`=0, and the next beat is treated as beat 0.
  - Assert `RND_CLR` during `LOOKUP` at `ROUND`=3: no S-box update, `ROUND`=0, and no `SB_DONE`.
- Key-write race:
  - Stimulus: write key0 = all-ones in the same cycle as beat 0.
  - Beat 0 uses the old key0. Beat 1 onward uses all-ones.
